// File: rtl/lsu_align.sv
// Alignment and sign-extension stage in front of the lsu: splits misaligned
// accesses into two word-aligned transactions and merges/extends load data.
module lsu_align (
  input  logic        clk,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        store_i,
  input  logic [2:0]  op_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        ready_o,
  output logic        done_o,
  output logic        err_o,
  output logic [31:0] rdata_o,
  output logic        lsu_read_o,
  output logic        lsu_write_o,
  output logic [3:0]  lsu_we_o,
  output logic [31:0] lsu_addr_o,
  output logic [31:0] lsu_data_o,
  input  logic [31:0] lsu_data_i,
  input  logic        lsu_valid_i
);

  localparam int unsigned DW = 32;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ACC0 = 3'd1;
  localparam logic [2:0] S_GAP  = 3'd2;
  localparam logic [2:0] S_ACC1 = 3'd3;
  localparam logic [2:0] S_RESP = 3'd4;

  logic [2:0]    state_q, state_d;
  logic          store_q, store_d;
  logic [2:0]    op_q, op_d;
  logic [DW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          err_q, err_d;
  logic [DW-1:0] merge_q, merge_d;
  logic [DW-1:0] rdata_q, rdata_d;

  logic [1:0]    offs;
  logic [3:0]    mask;
  logic [3:0]    nbytes;
  logic          misaligned;
  logic [7:0]    lanes;
  logic [4:0]    sh0, sh1;
  logic [DW-1:0] word0, word1;
  logic          in_acc0, in_acc1, in_acc;
  logic          legal_in;
  logic [DW-1:0] merged_c, ext_c;

  // Access geometry of the captured request
  always_comb begin
    offs = addr_q[1:0];
    case (op_q[1:0])
      2'b00:   begin mask = 4'b0001; nbytes = 4'd1; end
      2'b01:   begin mask = 4'b0011; nbytes = 4'd2; end
      default: begin mask = 4'b1111; nbytes = 4'd4; end
    endcase
    misaligned = (4'({2'b00, offs}) + nbytes) > 4'd4;
    lanes      = 8'({4'b0000, mask} << offs);
    sh0        = {offs, 3'b000};
    sh1        = 5'(6'd32 - {1'b0, offs, 3'b000});
    word0      = {addr_q[31:2], 2'b00};
    word1      = word0 + 32'd4;
  end

  assign in_acc0 = (state_q == S_ACC0);
  assign in_acc1 = (state_q == S_ACC1);
  assign in_acc  = in_acc0 | in_acc1;

  // Outputs decode from registered state only; IDLE/GAP/RESP drive zeros
  assign ready_o     = (state_q == S_IDLE);
  assign done_o      = (state_q == S_RESP);
  assign err_o       = (state_q == S_RESP) & err_q;
  assign rdata_o     = rdata_q;
  assign lsu_read_o  = in_acc & ~store_q;
  assign lsu_write_o = in_acc & store_q;
  assign lsu_we_o    = in_acc0 ? lanes[3:0] : (in_acc1 ? lanes[7:4] : 4'b0000);
  assign lsu_addr_o  = in_acc0 ? word0 : (in_acc1 ? word1 : '0);
  assign lsu_data_o  = in_acc0 ? (wdata_q << sh0) : (in_acc1 ? (wdata_q >> sh1) : '0);

  assign legal_in = store_i ? (op_i <= 3'b010) : !((op_i == 3'b011) || (op_i[2:1] == 2'b11));

  // Load data merge and size/sign extension
  always_comb begin
    merged_c = in_acc1 ? (merge_q | (lsu_data_i << sh1)) : (lsu_data_i >> sh0);
    case (op_q[1:0])
      2'b00:   ext_c = {{24{~op_q[2] & merged_c[7]}}, merged_c[7:0]};
      2'b01:   ext_c = {{16{~op_q[2] & merged_c[15]}}, merged_c[15:0]};
      default: ext_c = merged_c;
    endcase
  end

  always_comb begin
    state_d = state_q;
    store_d = store_q;
    op_d    = op_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    merge_d = merge_q;
    rdata_d = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (req_i) begin
          store_d = store_i;
          op_d    = op_i;
          addr_d  = addr_i;
          wdata_d = wdata_i;
          err_d   = ~legal_in;
          state_d = legal_in ? S_ACC0 : S_RESP;
        end
      end
      S_ACC0: begin
        if (lsu_valid_i) begin
          merge_d = merged_c;
          if (misaligned) begin
            state_d = S_GAP;
          end else begin
            state_d = S_RESP;
            if (!store_q) rdata_d = ext_c;
          end
        end
      end
      S_GAP:  state_d = S_ACC1;
      S_ACC1: begin
        if (lsu_valid_i) begin
          state_d = S_RESP;
          if (!store_q) rdata_d = ext_c;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      store_q <= 1'b0;
      op_q    <= 3'b000;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      merge_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      store_q <= store_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      merge_q <= merge_d;
      rdata_q <= rdata_d;
    end
  end

endmodule

// File: tb/tb_lsu_align.sv
// Scoreboard bench for lsu_align: the bench plays the lsu and checks every
// access it sees plus every completion against queued expectations.
module tb_lsu_align;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        req_i, store_i;
  logic [2:0]  op_i;
  logic [31:0] addr_i, wdata_i;
  logic        ready_o, done_o, err_o;
  logic [31:0] rdata_o;
  logic        lsu_read_o, lsu_write_o;
  logic [3:0]  lsu_we_o;
  logic [31:0] lsu_addr_o, lsu_data_o;
  logic [31:0] lsu_data_i;
  logic        lsu_valid_i;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad = 0;
  int          done_cnt = 0;
  logic [31:0] model_rdata = 32'h0;

  always #5 clk = ~clk;

  lsu_align dut (
    .clk(clk), .rst_i(rst_i), .req_i(req_i), .store_i(store_i), .op_i(op_i),
    .addr_i(addr_i), .wdata_i(wdata_i), .ready_o(ready_o), .done_o(done_o),
    .err_o(err_o), .rdata_o(rdata_o), .lsu_read_o(lsu_read_o),
    .lsu_write_o(lsu_write_o), .lsu_we_o(lsu_we_o), .lsu_addr_o(lsu_addr_o),
    .lsu_data_o(lsu_data_o), .lsu_data_i(lsu_data_i), .lsu_valid_i(lsu_valid_i)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Completion monitor: every done_o must match the oldest queued expectation
  always @(negedge clk) begin
    if (!rst_i && done_o) begin
      done_cnt++;
      if (sb.size() == 0) begin
        chk("spurious_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("rdata", rdata_o, e.rdata);
        chk("err", 32'(err_o), 32'(e.err));
        chk("ready_in_resp", 32'(ready_o), 32'd0);
      end
    end
  end

  // Drive a request when ready; returns at the negedge after acceptance
  task automatic issue(input logic st, input logic [2:0] op, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [31:0] load_val, input logic ill);
    int n = 0;
    exp_t e;
    while (!ready_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!ready_o) chk("ready_timeout", 32'(ready_o), 32'd1);
    store_i = st; op_i = op; addr_i = addr; wdata_i = wd; req_i = 1'b1;
    if (!st && !ill) model_rdata = load_val;
    e.rdata = model_rdata;
    e.err   = ill;
    sb.push_back(e);
    @(negedge clk);
    req_i = 1'b0;
  endtask

  // Act as the lsu for one access: check request fields, answer after lat cycles
  task automatic serve(input string tag, input logic st, input logic [31:0] ea,
                       input logic [3:0] ewe, input logic [31:0] ed,
                       input logic [31:0] ret, input int lat, input logic last);
    int n = 0;
    while (!(lsu_read_o || lsu_write_o) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_rw"}, {30'd0, lsu_read_o, lsu_write_o}, st ? 32'd1 : 32'd2);
    chk({tag, "_addr"}, lsu_addr_o, ea);
    chk({tag, "_we"}, 32'(lsu_we_o), 32'(ewe));
    if (st) chk({tag, "_data"}, lsu_data_o, ed);
    repeat (lat) @(negedge clk);
    lsu_valid_i = 1'b1;
    lsu_data_i  = ret;
    @(negedge clk);
    lsu_valid_i = 1'b0;
    lsu_data_i  = 32'hA5A5_5A5A;
    chk({tag, "_post_rw"}, {30'd0, lsu_read_o, lsu_write_o}, 32'd0);
    chk({tag, "_post_done"}, 32'(done_o), 32'(last));
  endtask

  initial begin
    int dc;
    rst_i = 1'b1; req_i = 1'b0; store_i = 1'b0; op_i = 3'b000;
    addr_i = '0; wdata_i = '0; lsu_data_i = '0; lsu_valid_i = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(ready_o), 32'd1);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_err", 32'(err_o), 32'd0);
    chk("rst_rdata", rdata_o, 32'd0);
    chk("rst_rw", {30'd0, lsu_read_o, lsu_write_o}, 32'd0);
    chk("rst_we", 32'(lsu_we_o), 32'd0);
    chk("rst_addr", lsu_addr_o, 32'd0);
    chk("rst_data", lsu_data_o, 32'd0);
    rst_i = 1'b0;
    @(negedge clk);

    // Aligned LW, plus ready timing around RESP
    issue(1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 1'b0);
    serve("lw", 1'b0, 32'h100, 4'b1111, 32'h0, 32'hDEADBEEF, 2, 1'b1);
    chk("rdy_resp", 32'(ready_o), 32'd0);
    @(negedge clk);
    chk("rdy_back", 32'(ready_o), 32'd1);

    issue(1'b0, 3'b000, 32'h203, 32'h0, 32'hFFFFFF80, 1'b0);
    serve("lb", 1'b0, 32'h200, 4'b1000, 32'h0, 32'h80FFFFFF, 0, 1'b1);
    issue(1'b0, 3'b100, 32'h203, 32'h0, 32'h00000080, 1'b0);
    serve("lbu", 1'b0, 32'h200, 4'b1000, 32'h0, 32'h80FFFFFF, 1, 1'b1);

    // Misaligned SH: two stores with a gap
    issue(1'b1, 3'b001, 32'h103, 32'h0000ABCD, 32'h0, 1'b0);
    serve("sh0", 1'b1, 32'h100, 4'b1000, 32'hCD000000, 32'h0, 1, 1'b0);
    serve("sh1", 1'b1, 32'h104, 4'b0001, 32'h000000AB, 32'h0, 0, 1'b1);

    // Misaligned LW wrapping past the top of the address space
    issue(1'b0, 3'b010, 32'hFFFFFFFE, 32'h0, 32'h56781234, 1'b0);
    serve("lww0", 1'b0, 32'hFFFFFFFC, 4'b1100, 32'h0, 32'h1234AAAA, 0, 1'b0);
    serve("lww1", 1'b0, 32'h00000000, 4'b0011, 32'h0, 32'hBBBB5678, 2, 1'b1);

    issue(1'b0, 3'b001, 32'h42, 32'h0, 32'hFFFF8001, 1'b0);
    serve("lh", 1'b0, 32'h40, 4'b1100, 32'h0, 32'h8001CCCC, 0, 1'b1);
    issue(1'b0, 3'b101, 32'h42, 32'h0, 32'h00008001, 1'b0);
    serve("lhu", 1'b0, 32'h40, 4'b1100, 32'h0, 32'h8001CCCC, 0, 1'b1);

    issue(1'b0, 3'b001, 32'h3, 32'h0, 32'hFFFFFFEE, 1'b0);
    serve("lhm0", 1'b0, 32'h0, 4'b1000, 32'h0, 32'hEE000000, 1, 1'b0);
    serve("lhm1", 1'b0, 32'h4, 4'b0001, 32'h0, 32'h123456FF, 1, 1'b1);

    issue(1'b1, 3'b000, 32'h7, 32'h00000055, 32'h0, 1'b0);
    serve("sb", 1'b1, 32'h4, 4'b1000, 32'h55000000, 32'h0, 0, 1'b1);

    // Illegal ops complete with err and no lsu access
    issue(1'b0, 3'b111, 32'h100, 32'h0, 32'h0, 1'b1);
    chk("ill_ld_rw", {30'd0, lsu_read_o, lsu_write_o}, 32'd0);
    chk("ill_ld_done", 32'(done_o), 32'd1);
    issue(1'b1, 3'b100, 32'h100, 32'h1, 32'h0, 1'b1);
    chk("ill_st_rw", {30'd0, lsu_read_o, lsu_write_o}, 32'd0);
    chk("ill_st_done", 32'(done_o), 32'd1);
    @(negedge clk);

    // Reset during ACC1 of a misaligned store abandons it
    issue(1'b1, 3'b001, 32'h103, 32'h0000ABCD, 32'h0, 1'b0);
    serve("rsh0", 1'b1, 32'h100, 4'b1000, 32'hCD000000, 32'h0, 0, 1'b0);
    @(negedge clk);
    chk("rst_acc1_wr", 32'(lsu_write_o), 32'd1);
    dc = done_cnt;
    rst_i = 1'b1;
    #1;
    chk("rst_mid_wr", 32'(lsu_write_o), 32'd0);
    chk("rst_mid_done", 32'(done_o), 32'd0);
    chk("rst_mid_ready", 32'(ready_o), 32'd1);
    sb.delete();
    model_rdata = 32'h0;
    @(negedge clk);
    rst_i = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_no_done", 32'(done_cnt), 32'(dc));

    issue(1'b1, 3'b010, 32'h0, 32'hCAFEF00D, 32'h0, 1'b0);
    serve("sw", 1'b1, 32'h0, 4'b1111, 32'hCAFEF00D, 32'h0, 1, 1'b1);
    repeat (3) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
